mux_scan_ctrl: RTL

Sequencer that sits directly upstream of the 4:1 select mux. It drives the mux select lines `s1`/`s2` through all four channels in order. On each channel it waits a programmable dwell time, then samples the mux output `y`. The four samples are packed into one 4-bit word, handed downstream over a valid/ready handshake.

---
 rtl/mux_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: walks s1/s2 over the channels, samples y after a dwell, emits a 4-bit word.
// Optional per-channel enable mask: define MUX_SCAN_MASK_EN to add the chan_mask port.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       s1,
    output logic       s2,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
`ifdef MUX_SCAN_MASK_EN
    ,
    input  logic [3:0] chan_mask
`endif
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [DW_W-1:0] dw_q, dw_d;
    logic [3:0]      shadow_q, shadow_d;
    logic [3:0]      word_q, word_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      start_mask;
    logic [2:0]      first;
    logic [2:0]      nxt;
    logic            begin_scan;

`ifdef MUX_SCAN_MASK_EN
    assign start_mask = chan_mask;
`else
    assign start_mask = 4'hF;
`endif

    // Lowest enabled channel at or above 'from'; bit 2 flags that one was found.
    function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r[2] && m[i[1:0]] && (3'(i) >= from)) begin
                r = {1'b1, i[1:0]};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        dw_d       = dw_q;
        shadow_d   = shadow_q;
        word_d     = word_q;
        sel_d      = sel_q;
        mask_d     = mask_q;
        nxt        = '0;
        begin_scan = 1'b0;
        first      = find_from(start_mask, 3'd0);

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (start) begin_scan = 1'b1;
            end
            SETTLE: begin
                if (dw_q == DW_MAX) begin
                    shadow_d[ch_q] = y;
                    nxt = find_from(mask_q, {1'b0, ch_q} + 3'd1);
                    if (nxt[2]) begin
                        ch_d  = nxt[1:0];
                        dw_d  = '0;
                        sel_d = nxt[1:0];
                    end else begin
                        state_d = DONE;
                        word_d  = shadow_d;
                        sel_d   = '0;
                    end
                end else begin
                    dw_d = dw_q + DW_W'(1);
                end
            end
            DONE: begin
                sel_d = '0;
                if (word_ready) begin
                    if (start) begin_scan = 1'b1;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Common scan entry from IDLE and from a DONE handshake; an empty mask finishes at once.
        if (begin_scan) begin
            mask_d   = start_mask;
            shadow_d = '0;
            dw_d     = '0;
            if (first[2]) begin
                state_d = SETTLE;
                ch_d    = first[1:0];
                sel_d   = first[1:0];
            end else begin
                state_d = DONE;
                ch_d    = '0;
                sel_d   = '0;
                word_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            dw_q     <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            sel_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            dw_q     <= dw_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
        end
    end

    assign s1         = sel_q[1];
    assign s2         = sel_q[0];
    assign word       = word_q;
    assign word_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule
